frv_pipeline_memory: RTL and testbench

Memory stage of the frv pipeline and the consumer end of the execute-stage s3_* valid/busy interface. It accepts execute results, issues load/store transactions on the data memory bus and formats load data. It detects misaligned and bus-error accesses, then forwards results through its own pipeline register to writeback (s4_*). Non-LSU instructions pass through with one cycle of latency.

---
 rtl/frv_pipeline_memory_pkg.sv | 50 +++++
 rtl/frv_lsu_format.sv | 39 +++
 rtl/frv_pipeline_memory.sv | 162 ++++++++++++++++
 tb/tb_frv_pipeline_memory.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/frv_pipeline_memory_pkg.sv
// Shared constants, encodings and the s4 payload layout for the frv memory stage.
package frv_pipeline_memory_pkg;

    localparam int XLEN       = 32;
    localparam int PIPE_REG_W = 82;

    // uop bit positions for LSU operations
    localparam int LSU_LOAD     = 0;
    localparam int LSU_STORE    = 1;
    localparam int LSU_SIGNED   = 2;
    localparam int LSU_WIDTH_LO = 3;

    // functional unit one-hot bit positions
    localparam int FU_ALU = 0;
    localparam int FU_LSU = 2;

    localparam logic [XLEN-1:0] TRAP_LDALIGN  = 32'd4;
    localparam logic [XLEN-1:0] TRAP_LDACCESS = 32'd5;
    localparam logic [XLEN-1:0] TRAP_STALIGN  = 32'd6;
    localparam logic [XLEN-1:0] TRAP_STACCESS = 32'd7;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_width_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RSP,
        ST_DONE,
        ST_DRAIN
    } mem_state_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] opr_a;
        logic [XLEN-1:0] opr_b;
        logic [4:0]      uop;
        logic [4:0]      fu;
        logic            trap;
        logic [1:0]      size;
    } s4_pipe_t;

    function automatic logic is_misaligned(input lsu_width_t width, input logic [1:0] addr_lo);
        return ((width == LSU_HALF) && addr_lo[0]) ||
               ((width == LSU_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/frv_lsu_format.sv
// Combinational store lane replication / byte strobes and load byte extraction.
module frv_lsu_format
    import frv_pipeline_memory_pkg::*;
(
    input  logic [1:0]      i_addr_lo,
    input  lsu_width_t      i_width,
    input  logic            i_signed,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_strb,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] w_shift;

    assign w_shift = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        o_strb  = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = w_shift;
        case (i_width)
            LSU_BYTE: begin
                o_strb  = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
            end
            LSU_HALF: begin
                o_strb  = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/frv_pipeline_memory.sv
// frv memory stage: single-outstanding data bus master feeding the s4 pipeline register.
module frv_pipeline_memory
    import frv_pipeline_memory_pkg::*;
(
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic [4:0]      s3_rd,
    input  logic [XLEN-1:0] s3_opr_a,
    input  logic [XLEN-1:0] s3_opr_b,
    input  logic [4:0]      s3_uop,
    input  logic [4:0]      s3_fu,
    input  logic            s3_trap,
    input  logic [1:0]      s3_size,
    input  logic [31:0]     s3_instr,
    input  logic            s3_valid,
    output logic            s3_busy,
    output logic [4:0]      fwd_s3_rd,
    output logic [XLEN-1:0] fwd_s3_wdata,
    output logic            fwd_s3_load,
    output logic            dmem_req,
    input  logic            dmem_gnt,
    output logic            dmem_wen,
    output logic [3:0]      dmem_strb,
    output logic [31:0]     dmem_addr,
    output logic [31:0]     dmem_wdata,
    input  logic            dmem_recv,
    output logic            dmem_ack,
    input  logic            dmem_error,
    input  logic [31:0]     dmem_rdata,
    output logic [4:0]      s4_rd,
    output logic [XLEN-1:0] s4_opr_a,
    output logic [XLEN-1:0] s4_opr_b,
    output logic [4:0]      s4_uop,
    output logic [4:0]      s4_fu,
    output logic            s4_trap,
    output logic [1:0]      s4_size,
    output logic            s4_valid,
    input  logic            s4_busy
);

    mem_state_t            r_state, w_next_state;
    logic [PIPE_REG_W-1:0] r_s4;
    logic                  r_s4_valid;
    logic [XLEN-1:0]       r_rsp_data;
    logic                  r_rsp_err;

    logic            w_load, w_store, w_misaligned, w_mem_op;
    logic            w_stall, w_lsu_push, w_pass_push, w_from_mem;
    logic            w_rsp_err;
    logic [XLEN-1:0] w_fmt_rdata, w_rsp_data;
    lsu_width_t      w_width;
    s4_pipe_t        w_s4_next, w_s4;
    logic            w_unused;

    assign w_unused     = &{1'b0, s3_instr};
    assign w_load       = s3_fu[FU_LSU] && s3_uop[LSU_LOAD];
    assign w_store      = s3_fu[FU_LSU] && s3_uop[LSU_STORE];
    assign w_width      = lsu_width_t'(s3_uop[LSU_WIDTH_LO+:2]);
    assign w_misaligned = (w_load || w_store) && !s3_trap && is_misaligned(w_width, s3_opr_a[1:0]);
    assign w_mem_op     = s3_valid && (w_load || w_store) && !s3_trap && !w_misaligned;

    frv_lsu_format u_format (
        .i_addr_lo (s3_opr_a[1:0]),
        .i_width   (w_width),
        .i_signed  (s3_uop[LSU_SIGNED]),
        .i_wdata   (s3_opr_b),
        .i_rdata   (dmem_rdata),
        .o_strb    (dmem_strb),
        .o_wdata   (dmem_wdata),
        .o_rdata   (w_fmt_rdata)
    );

    assign dmem_addr    = {s3_opr_a[31:2], 2'b00};
    assign dmem_wen     = w_store;
    assign dmem_ack     = 1'b1;
    assign fwd_s3_rd    = s3_rd;
    assign fwd_s3_wdata = s3_opr_a;
    assign fwd_s3_load  = s3_valid && w_load;

    always_ff @(posedge g_clk) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (!g_resetn) r_state <= ST_IDLE;
        else           r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (dmem_req && dmem_gnt) w_next_state = ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (flush)          w_next_state = dmem_recv ? ST_IDLE : ST_DRAIN;
                else if (dmem_recv) w_next_state = s4_busy ? ST_DONE : ST_IDLE;
            end
            ST_DONE:     if (flush || !s4_busy) w_next_state = ST_IDLE;
            ST_DRAIN:    if (dmem_recv) w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // The held s3 op is released only in the cycle its result enters s4.
    always_comb begin
        w_stall     = s4_valid && s4_busy;
        dmem_req    = (r_state == ST_IDLE) && w_mem_op && !flush;
        w_lsu_push  = !flush && !s4_busy &&
                      (((r_state == ST_WAIT_RSP) && dmem_recv) || (r_state == ST_DONE));
        w_pass_push = (r_state == ST_IDLE) && s3_valid && !w_mem_op && !w_stall && !flush;
        s3_busy     = !w_lsu_push && ((r_state != ST_IDLE) || w_mem_op || w_stall);
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if ((r_state == ST_WAIT_RSP) && dmem_recv) begin
            r_rsp_data <= w_fmt_rdata;
            r_rsp_err  <= dmem_error;
        end
    end

    assign w_from_mem = (r_state != ST_IDLE);
    assign w_rsp_data = (r_state == ST_DONE) ? r_rsp_data : w_fmt_rdata;
    assign w_rsp_err  = (r_state == ST_DONE) ? r_rsp_err  : dmem_error;

    always_comb begin
        w_s4_next.rd    = s3_rd;
        w_s4_next.uop   = s3_uop;
        w_s4_next.fu    = s3_fu;
        w_s4_next.size  = s3_size;
        w_s4_next.trap  = s3_trap || w_misaligned || (w_from_mem && w_rsp_err);
        w_s4_next.opr_a = (w_from_mem && w_load && !w_rsp_err) ? w_rsp_data : s3_opr_a;
        w_s4_next.opr_b = s3_opr_b;
        if (s3_trap)                      w_s4_next.opr_b = s3_opr_b;
        else if (w_misaligned)            w_s4_next.opr_b = w_load ? TRAP_LDALIGN : TRAP_STALIGN;
        else if (w_from_mem && w_rsp_err) w_s4_next.opr_b = w_load ? TRAP_LDACCESS : TRAP_STACCESS;
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_s4_valid <= 1'b0;
            r_s4       <= '0;
        end else if (flush) begin
            r_s4_valid <= 1'b0;
        end else if (w_lsu_push || w_pass_push) begin
            r_s4_valid <= 1'b1;
            r_s4       <= w_s4_next;
        end else if (!s4_busy) begin
            r_s4_valid <= 1'b0;
        end
    end

    assign w_s4     = s4_pipe_t'(r_s4);
    assign s4_valid = r_s4_valid;
    assign s4_rd    = w_s4.rd;
    assign s4_opr_a = w_s4.opr_a;
    assign s4_opr_b = w_s4.opr_b;
    assign s4_uop   = w_s4.uop;
    assign s4_fu    = w_s4.fu;
    assign s4_trap  = w_s4.trap;
    assign s4_size  = w_s4.size;

endmodule

// File: tb/tb_frv_pipeline_memory.sv
// Self-checking bench for frv_pipeline_memory: directed cases, flush/drain and random ops vs a reference model.
module tb_frv_pipeline_memory;
    import frv_pipeline_memory_pkg::*;

    logic        g_clk, g_resetn, flush;
    logic [4:0]  s3_rd, s3_uop, s3_fu;
    logic [31:0] s3_opr_a, s3_opr_b, s3_instr;
    logic        s3_trap, s3_valid, s3_busy;
    logic [1:0]  s3_size;
    logic [4:0]  fwd_s3_rd;
    logic [31:0] fwd_s3_wdata;
    logic        fwd_s3_load;
    logic        dmem_req, dmem_gnt, dmem_wen, dmem_recv, dmem_ack, dmem_error;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [4:0]  s4_rd, s4_uop, s4_fu;
    logic [31:0] s4_opr_a, s4_opr_b;
    logic        s4_trap, s4_valid, s4_busy;
    logic [1:0]  s4_size;

    int total = 0;
    int bad   = 0;

    frv_pipeline_memory dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .s3_rd(s3_rd), .s3_opr_a(s3_opr_a), .s3_opr_b(s3_opr_b), .s3_uop(s3_uop),
        .s3_fu(s3_fu), .s3_trap(s3_trap), .s3_size(s3_size), .s3_instr(s3_instr),
        .s3_valid(s3_valid), .s3_busy(s3_busy),
        .fwd_s3_rd(fwd_s3_rd), .fwd_s3_wdata(fwd_s3_wdata), .fwd_s3_load(fwd_s3_load),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_recv(dmem_recv),
        .dmem_ack(dmem_ack), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .s4_rd(s4_rd), .s4_opr_a(s4_opr_a), .s4_opr_b(s4_opr_b), .s4_uop(s4_uop),
        .s4_fu(s4_fu), .s4_trap(s4_trap), .s4_size(s4_size),
        .s4_valid(s4_valid), .s4_busy(s4_busy)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] mk_uop(input bit ld, input bit st, input bit sgn, input logic [1:0] w);
        logic [4:0] u;
        u = '0;
        u[LSU_LOAD] = ld;
        u[LSU_STORE] = st;
        u[LSU_SIGNED] = sgn;
        u[LSU_WIDTH_LO+:2] = w;
        return u;
    endfunction

    // Drives one op at a negedge, plays the bus and writeback, checks against the model.
    task automatic run_op(input string tag, input logic [4:0] uop, input logic [4:0] fu,
                          input bit trap, input logic [31:0] addr, input logic [31:0] opb,
                          input int gnt_dly, input int rsp_dly, input int busy_cyc,
                          input bit err, input logic [31:0] rdata);
        bit ld, st, mis, mem, granted, acc, will_grant, stable, first;
        logic [1:0]  w, lo;
        logic [3:0]  e_strb, f_strb;
        logic [31:0] e_wdata, e_addr, e_a, e_b, sh, ld_val, f_addr, f_wdata;
        int req_n, g_iter, r_iter, acc_iter, e_iter;

        w   = uop[LSU_WIDTH_LO+:2];
        lo  = addr[1:0];
        ld  = fu[FU_LSU] && uop[LSU_LOAD];
        st  = fu[FU_LSU] && uop[LSU_STORE];
        mis = (ld || st) && !trap && ((w == 2'd1 && addr % 2 != 0) || (w == 2'd2 && addr % 4 != 0));
        mem = (ld || st) && !trap && !mis;
        e_strb  = (w == 2'd0) ? 4'(1 << lo) : (w == 2'd1) ? 4'(3 << lo) : 4'hF;
        e_wdata = (w == 2'd0) ? (opb % 256) * 32'h01010101 :
                  (w == 2'd1) ? (opb % 65536) * 32'h00010001 : opb;
        e_addr  = addr - (addr % 4);
        sh = rdata >> (8 * lo);
        if (w == 2'd0) begin
            ld_val = sh % 256;
            if (uop[LSU_SIGNED] && ld_val >= 128) ld_val = ld_val - 256;
        end else if (w == 2'd1) begin
            ld_val = sh % 65536;
            if (uop[LSU_SIGNED] && ld_val >= 32768) ld_val = ld_val - 65536;
        end else begin
            ld_val = sh;
        end
        e_a = (mem && ld && !err) ? ld_val : addr;
        e_b = trap ? opb : mis ? (ld ? 32'd4 : 32'd6) : (mem && err) ? (ld ? 32'd5 : 32'd7) : opb;
        e_iter = mem ? gnt_dly + 1 + rsp_dly + busy_cyc : 0;

        s3_rd = 5'($urandom); s3_uop = uop; s3_fu = fu; s3_trap = trap;
        s3_opr_a = addr; s3_opr_b = opb; s3_size = 2'($urandom); s3_instr = $urandom;
        s3_valid = 1'b1; dmem_rdata = rdata; dmem_error = err;
        granted = 0; acc = 0; req_n = 0; g_iter = -100; r_iter = -100; acc_iter = -1;
        stable = 1; first = 1; f_strb = '0; f_addr = '0; f_wdata = '0;

        for (int cyc = 0; cyc < 40; cyc++) begin
            dmem_recv = granted && (cyc == g_iter + 1 + rsp_dly);
            if (dmem_recv) r_iter = cyc;
            s4_busy = (r_iter >= 0) && (cyc < r_iter + busy_cyc);
            #1;
            if (dmem_req) begin
                req_n++;
                if (first) begin
                    first = 0;
                    f_strb = dmem_strb; f_addr = dmem_addr; f_wdata = dmem_wdata;
                    check({tag, "_addr"}, dmem_addr, e_addr);
                    check({tag, "_strb"}, {28'd0, dmem_strb}, {28'd0, e_strb});
                    check({tag, "_wen"}, {31'd0, dmem_wen}, {31'd0, st});
                    if (st) check({tag, "_wdata"}, dmem_wdata, e_wdata);
                end else if (dmem_strb !== f_strb || dmem_addr !== f_addr || dmem_wdata !== f_wdata) begin
                    stable = 0;
                end
            end
            dmem_gnt = dmem_req && !granted && (req_n > gnt_dly);
            will_grant = dmem_gnt;
            #1;
            acc = !s3_busy;
            @(posedge g_clk);
            if (will_grant) begin granted = 1; g_iter = cyc; end
            @(negedge g_clk);
            dmem_gnt = 1'b0; dmem_recv = 1'b0;
            if (acc) begin acc_iter = cyc; break; end
        end
        s3_valid = 1'b0;
        s4_busy  = 1'b0;
        check({tag, "_req_cycles"}, req_n, mem ? gnt_dly + 1 : 0);
        check({tag, "_req_stable"}, {31'd0, stable}, 32'd1);
        check({tag, "_accept_cycle"}, acc_iter, e_iter);
        check({tag, "_s4_valid"}, {31'd0, s4_valid}, 32'd1);
        check({tag, "_s4_opr_a"}, s4_opr_a, e_a);
        check({tag, "_s4_opr_b"}, s4_opr_b, e_b);
        check({tag, "_s4_trap"}, {31'd0, s4_trap}, {31'd0, (trap || mis || (mem && err))});
        check({tag, "_s4_fields"}, {15'd0, s4_rd, s4_uop, s4_fu, s4_size},
              {15'd0, s3_rd, uop, fu, s3_size});
        @(negedge g_clk);
        check({tag, "_s4_drain"}, {31'd0, s4_valid}, 32'd0);
    endtask

    localparam logic [4:0] FU_L = 5'(1 << FU_LSU);
    localparam logic [4:0] FU_A = 5'(1 << FU_ALU);

    initial begin
        g_resetn = 1'b0; flush = 1'b0; s3_valid = 1'b0; s3_rd = '0; s3_uop = '0; s3_fu = '0;
        s3_opr_a = '0; s3_opr_b = '0; s3_trap = 1'b0; s3_size = '0; s3_instr = '0;
        dmem_gnt = 1'b0; dmem_recv = 1'b0; dmem_error = 1'b0; dmem_rdata = '0; s4_busy = 1'b0;
        repeat (3) @(negedge g_clk);
        check("rst_s4_valid", {31'd0, s4_valid}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_s4_data", s4_opr_a | s4_opr_b, 32'd0);
        check("rst_s4_ctrl", {20'd0, s4_rd, s4_uop, s4_trap, s4_size}, 32'd0);
        check("rst_s3_busy", {31'd0, s3_busy}, 32'd0);
        check("dmem_ack", {31'd0, dmem_ack}, 32'd1);
        g_resetn = 1'b1;
        @(negedge g_clk);

        // opcode, fu, trap, addr, opr_b, gnt_dly, rsp_dly, busy, err, rdata
        run_op("lw",     mk_uop(1, 0, 1, 2'd2), FU_L, 0, 32'h1000, 32'h0, 0, 0, 0, 0, 32'hDEADBEEF);
        run_op("lb",     mk_uop(1, 0, 1, 2'd0), FU_L, 0, 32'h2003, 32'h0, 0, 0, 0, 0, 32'h80123456);
        run_op("lbu",    mk_uop(1, 0, 0, 2'd0), FU_L, 0, 32'h2003, 32'h0, 0, 0, 0, 0, 32'h80123456);
        run_op("sh",     mk_uop(0, 1, 0, 2'd1), FU_L, 0, 32'h0102, 32'h1234BEEF, 3, 0, 0, 0, 32'h0);
        run_op("lw_mis", mk_uop(1, 0, 1, 2'd2), FU_L, 0, 32'h1001, 32'h0, 0, 0, 0, 0, 32'h0);
        run_op("sw_mis", mk_uop(0, 1, 0, 2'd2), FU_L, 0, 32'h1002, 32'h55AA55AA, 0, 0, 0, 0, 32'h0);
        run_op("lh_done", mk_uop(1, 0, 1, 2'd1), FU_L, 0, 32'h4002, 32'h0, 1, 1, 2, 0, 32'h9ABC1234);
        run_op("lw_err", mk_uop(1, 0, 1, 2'd2), FU_L, 0, 32'h5000, 32'h0, 0, 0, 0, 1, 32'h11111111);
        run_op("sb_err", mk_uop(0, 1, 0, 2'd0), FU_L, 0, 32'h5001, 32'hA5, 0, 1, 1, 1, 32'h0);
        run_op("trap",   mk_uop(1, 0, 0, 2'd2), FU_L, 1, 32'h6001, 32'd2, 0, 0, 0, 0, 32'h0);

        // flush while waiting for the response: drain it, produce nothing
        s3_rd = 5'd7; s3_uop = mk_uop(1, 0, 0, 2'd2); s3_fu = FU_L; s3_trap = 1'b0;
        s3_opr_a = 32'h3000; s3_opr_b = '0; s3_valid = 1'b1;
        #1;
        check("flush_req", {31'd0, dmem_req}, 32'd1);
        check("fwd_load", {31'd0, fwd_s3_load}, 32'd1);
        dmem_gnt = 1'b1;
        @(posedge g_clk); @(negedge g_clk);
        dmem_gnt = 1'b0;
        #1;
        check("flush_wait_busy", {31'd0, s3_busy}, 32'd1);
        flush = 1'b1;
        @(posedge g_clk); @(negedge g_clk);
        flush = 1'b0; s3_valid = 1'b0;
        #1;
        check("flush_drain_busy", {31'd0, s3_busy}, 32'd1);
        check("flush_no_s4", {31'd0, s4_valid}, 32'd0);
        @(posedge g_clk); @(negedge g_clk);
        dmem_recv = 1'b1;
        #1;
        check("flush_recv_busy", {31'd0, s3_busy}, 32'd1);
        @(posedge g_clk); @(negedge g_clk);
        dmem_recv = 1'b0;
        #1;
        check("flush_idle_busy", {31'd0, s3_busy}, 32'd0);
        check("flush_idle_s4", {31'd0, s4_valid}, 32'd0);
        run_op("add_after_flush", 5'd3, FU_A, 0, 32'h12345678, 32'h9, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [1:0] w;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            w = 2'($urandom_range(0, 2));
            a = $urandom;
            case (kind)
                0: run_op("rnd_ld", mk_uop(1, 0, 1'($urandom), w), FU_L, 0, a, $urandom,
                          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                          ($urandom_range(0, 7) == 0), $urandom);
                1: run_op("rnd_st", mk_uop(0, 1, 0, w), FU_L, 0, a, $urandom,
                          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                          ($urandom_range(0, 7) == 0), $urandom);
                2: run_op("rnd_alu", 5'($urandom), FU_A, 0, a, $urandom, 0, 0, 0, 0, $urandom);
                default: run_op("rnd_trap", mk_uop(1, 0, 0, w), FU_L, 1, a, $urandom, 0, 0, 0, 0, $urandom);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
